// File: rtl/cntr12_pkg.sv
// Shared definitions for the mod-12 counter subsystem: modulus, width,
// monitor state encoding and the wrap rule used by RTL and benches.
package cntr12_pkg;

  localparam int CNTR12_MOD = 12;
  localparam int CNTR12_W   = 4;

  // ACQ: no reference sample yet; TRACK: counting correct increments
  // towards lock; LOCKED: following a confirmed sequence.
  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Successor of p in the 0..CNTR12_MOD-1 sequence; never exceeds MOD-1.
  function automatic logic [CNTR12_W-1:0] next_count(input logic [CNTR12_W-1:0] p);
    return (p == CNTR12_W'(CNTR12_MOD - 1)) ? '0 : p + CNTR12_W'(1);
  endfunction

endpackage

// File: rtl/cntr12_mon_sat_cntr.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on
// clr or reset.
module sat_cntr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  // NOTE: non-blocking (<=) in clocked blocks so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cntr12_mon.sv
// Sequence monitor for the mod-12 counter bus. Acquires lock on the
// 0..MODULUS-1 wrap sequence, pulses seq_err / range_err on violations and
// keeps a saturating error total plus a free-running wrap count.
// All outputs are registered: a sample's effect is visible one cycle later.
module cntr12_mon
  import cntr12_pkg::*;
#(
  parameter int MODULUS = CNTR12_MOD,
  parameter int W       = CNTR12_W,
  parameter int LOCK_N  = 3,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [W-1:0]  q_in,
  output logic          locked,
  output logic          seq_err,
  output logic          range_err,
  output logic [W-1:0]  exp_q,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] wrap_count
);

  // Good-increment counter only needs to reach LOCK_N.
  localparam int            GW       = $clog2(LOCK_N + 1);
  localparam logic [W-1:0]  MAX_V    = W'(MODULUS - 1);
  localparam logic [GW:0]   LOCK_TGT = (GW + 1)'(LOCK_N);

  // Wrap rule at this instance's modulus and width.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] p);
    return (p == MAX_V) ? '0 : p + W'(1);
  endfunction

  mon_state_t    state_q,     state_d;
  logic [W-1:0]  prev_q,      prev_d;
  logic [GW-1:0] good_q,      good_d;
  logic          locked_q,    locked_d;
  logic          seq_err_q,   seq_err_d;
  logic          range_err_q, range_err_d;
  logic [W-1:0]  exp_val_q,   exp_val_d;
  logic [CW-1:0] wrap_q,      wrap_d;
  logic          err_inc;

  logic          legal;
  logic          match;
  logic          wrap_hit;
  logic [GW:0]   good_inc;

  assign legal    = (q_in <= MAX_V);
  assign match    = (q_in == nxt(prev_q));
  assign wrap_hit = (prev_q == MAX_V) && (q_in == '0);
  assign good_inc = {1'b0, good_q} + (GW + 1)'(1);

  // Next-state and output decode for one sample; range check has priority.
  // NOTE: every signal gets a default before any branch so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    locked_d    = locked_q;
    seq_err_d   = 1'b0;
    range_err_d = 1'b0;
    wrap_d      = wrap_q;
    err_inc     = 1'b0;

    if (en) begin
      if (!legal) begin
        // Out-of-range value: drop back to acquisition, keep reference.
        range_err_d = 1'b1;
        err_inc     = 1'b1;
        state_d     = ACQ;
        good_d      = '0;
        locked_d    = 1'b0;
      end else begin
        // Any legal sample becomes the new reference.
        prev_d = q_in;
        if ((state_q != ACQ) && wrap_hit) begin
          wrap_d = wrap_q + CW'(1);
        end
        unique case (state_q)
          ACQ: begin
            good_d   = '0;
            locked_d = 1'b0;
            state_d  = TRACK;
          end
          TRACK: begin
            if (match) begin
              good_d = good_inc[GW-1:0];
              if (good_inc == LOCK_TGT) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              // Still acquiring: restart the run quietly.
              good_d = '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              seq_err_d = 1'b1;
              err_inc   = 1'b1;
              locked_d  = 1'b0;
              good_d    = '0;
              state_d   = TRACK;
            end
          end
          default: begin
            state_d  = ACQ;
            good_d   = '0;
            locked_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Expected value tracks the reference, so it holds whenever prev holds.
  assign exp_val_d = nxt(prev_d);

  // Monitor state and registered outputs; reset overrides any sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACQ;
      prev_q      <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      exp_val_q   <= '0;
      wrap_q      <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      range_err_q <= range_err_d;
      exp_val_q   <= en ? exp_val_d : exp_val_q;
      wrap_q      <= wrap_d;
    end
  end

  sat_cntr #(
    .WIDTH (CW)
  ) u_err_cntr (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (1'b0),
    .cnt   (err_count)
  );

  assign locked     = locked_q;
  assign seq_err    = seq_err_q;
  assign range_err  = range_err_q;
  assign exp_q      = exp_val_q;
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_cntr12_mon.sv
// Directed bench for cntr12_mon: a vector table for the main sequence
// plus hand-written wrap and saturation runs.
module tb_cntr12_mon;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] q_in;
  logic       locked;
  logic       seq_err;
  logic       range_err;
  logic [3:0] exp_q;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cntr12_mon #(
    .MODULUS (12),
    .W       (4),
    .LOCK_N  (3),
    .CW      (8)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .q_in       (q_in),
    .locked     (locked),
    .seq_err    (seq_err),
    .range_err  (range_err),
    .exp_q      (exp_q),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] q;
    logic       lk;
    logic       se;
    logic       re;
    logic [3:0] eq;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic e, input int q,
                             input logic lk, input logic se, input logic re,
                             input int eq, input int ec, input int wc);
    vec_t r;
    r.rst = rst; r.en = e; r.q = 4'(q);
    r.lk = lk; r.se = se; r.re = re;
    r.eq = 4'(eq); r.ec = 8'(ec); r.wc = 8'(wc);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample just after
  // the rising edge that registers them.
  task automatic drive(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    reset = r;
    en    = e;
    q_in  = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic lk, input logic se,
                           input logic re, input logic [3:0] eq,
                           input logic [7:0] ec, input logic [7:0] wc);
    check({tag, " locked"},     32'(locked),     32'(lk));
    check({tag, " seq_err"},    32'(seq_err),    32'(se));
    check({tag, " range_err"},  32'(range_err),  32'(re));
    check({tag, " exp_q"},      32'(exp_q),      32'(eq));
    check({tag, " err_count"},  32'(err_count),  32'(ec));
    check({tag, " wrap_count"}, 32'(wrap_count), 32'(wc));
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    q_in  = '0;

    // Main sequence: lock, gap, mismatch, relock, wrap, range error,
    // stall in TRACK and LOCKED, reset mid-lock, wrap while unlocked.
    tbl.push_back(v(0,1, 0, 0,0,0, 1,0,0));
    tbl.push_back(v(0,1, 1, 0,0,0, 2,0,0));
    tbl.push_back(v(0,1, 2, 0,0,0, 3,0,0));
    tbl.push_back(v(0,1, 3, 1,0,0, 4,0,0));
    tbl.push_back(v(0,0, 9, 1,0,0, 4,0,0));
    tbl.push_back(v(0,1, 4, 1,0,0, 5,0,0));
    tbl.push_back(v(0,1, 5, 1,0,0, 6,0,0));
    tbl.push_back(v(0,1, 7, 0,1,0, 8,1,0));
    tbl.push_back(v(0,0, 0, 0,0,0, 8,1,0));
    tbl.push_back(v(0,1, 8, 0,0,0, 9,1,0));
    tbl.push_back(v(0,1, 9, 0,0,0,10,1,0));
    tbl.push_back(v(0,1,10, 1,0,0,11,1,0));
    tbl.push_back(v(0,1,11, 1,0,0, 0,1,0));
    tbl.push_back(v(0,1, 0, 1,0,0, 1,1,1));
    tbl.push_back(v(0,1,13, 0,0,1, 1,2,1));
    tbl.push_back(v(0,1, 1, 0,0,0, 2,2,1));
    tbl.push_back(v(0,1, 2, 0,0,0, 3,2,1));
    tbl.push_back(v(0,1, 3, 0,0,0, 4,2,1));
    tbl.push_back(v(0,1, 3, 0,0,0, 4,2,1));
    tbl.push_back(v(0,1, 4, 0,0,0, 5,2,1));
    tbl.push_back(v(0,1, 5, 0,0,0, 6,2,1));
    tbl.push_back(v(0,1, 6, 1,0,0, 7,2,1));
    tbl.push_back(v(0,1, 6, 0,1,0, 7,3,1));
    tbl.push_back(v(0,1, 7, 0,0,0, 8,3,1));
    tbl.push_back(v(0,1, 8, 0,0,0, 9,3,1));
    tbl.push_back(v(0,1, 9, 1,0,0,10,3,1));
    tbl.push_back(v(1,1, 3, 0,0,0, 0,0,0));
    tbl.push_back(v(0,0, 0, 0,0,0, 0,0,0));
    tbl.push_back(v(0,1,11, 0,0,0, 0,0,0));
    tbl.push_back(v(0,1, 0, 0,0,0, 1,0,1));

    // Reset state.
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 4'd5);
    check_all("reset", 0, 0, 0, 4'd0, 8'd0, 8'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].q);
      check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].se, tbl[i].re,
                tbl[i].eq, tbl[i].ec, tbl[i].wc);
    end

    // Wrap counting: lock on 8..11, wrap once, then two more full laps.
    drive(1'b1, 1'b0, 4'd0);
    for (int k = 8; k <= 11; k++) drive(1'b0, 1'b1, 4'(k));
    check("wrap lock11 locked", 32'(locked), 32'd1);
    drive(1'b0, 1'b1, 4'd0);
    check("wrap first count", 32'(wrap_count), 32'd1);
    check("wrap first exp_q", 32'(exp_q), 32'd1);
    check("wrap first seq_err", 32'(seq_err), 32'd0);
    for (int lap = 0; lap < 2; lap++) begin
      for (int k = 1; k <= 11; k++) drive(1'b0, 1'b1, 4'(k));
      drive(1'b0, 1'b1, 4'd0);
    end
    check("wrap laps count", 32'(wrap_count), 32'd3);
    check("wrap laps locked", 32'(locked), 32'd1);
    check("wrap laps err_count", 32'(err_count), 32'd0);

    // Saturation: 300 alternating 14/15 samples.
    drive(1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0) ? 4'd14 : 4'd15);
      if (k == 253) check("sat err_count 254", 32'(err_count), 32'd254);
      if (k == 254) check("sat err_count 255", 32'(err_count), 32'd255);
      if (k == 255) check("sat err_count hold", 32'(err_count), 32'd255);
    end
    check("sat err_count end", 32'(err_count), 32'd255);
    check("sat range_err", 32'(range_err), 32'd1);
    check("sat locked", 32'(locked), 32'd0);
    check("sat seq_err", 32'(seq_err), 32'd0);
    drive(1'b0, 1'b0, 4'd15);
    check("sat idle range_err", 32'(range_err), 32'd0);
    check("sat idle err_count", 32'(err_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr12_mon.md
Name: cntr12_mon

Overview:
- Sequence monitor that sits on the consumer side of the mod-12 counter output bus.
- Samples the 4-bit count and acquires lock onto the 0..11 wrap sequence.
- Flags out-of-sequence and out-of-range values, and keeps saturating error and wrap statistics.
- Used inline in the counter subsystem and as a reusable checker in benches.

Parameters:
- MODULUS, 12, count modulus; legal values 0..MODULUS-1
- W, 4, count width; requires 2**W >= MODULUS
- LOCK_N, 3, consecutive correct increments needed to assert lock (>=1)
- CW, 8, width of err_count and wrap_count

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  sample strobe; q_in is valid this cycle
- q_in  in  W  observed count value
- locked  out  1  monitor locked to a valid sequence
- seq_err  out  1  one-cycle pulse: sequence mismatch while locked
- range_err  out  1  one-cycle pulse: q_in >= MODULUS
- exp_q  out  W  next expected value (valid when locked)
- err_count  out  CW  saturating total of seq_err and range_err events
- wrap_count  out  CW  modulo-2**CW count of observed MODULUS-1 -> 0 transitions

Behaviour:
- Clocking/reset: single clock. Reset is synchronous and active-high; the clock port is named clk and the reset port is named reset.
- All outputs are registered. Each sample's effects appear the cycle after the en edge.
- Reset values:
  - locked=0, seq_err=0, range_err=0, exp_q=0, err_count=0, wrap_count=0
  - FSM=ACQ, prev=0, good=0
- en=0: no state change. seq_err and range_err drop to 0. Counters hold.
- Expected value: nxt(p) = (p == MODULUS-1) ? 0 : p+1. Computed in W bits with no overflow past MODULUS-1.
- FSM states:
  - ACQ (no reference sample)
  - TRACK (good < LOCK_N)
  - LOCKED
- Range check has priority in every state. If en and q_in >= MODULUS:
  - range_err=1, err_count+1 (saturating)
  - go to ACQ, good=0, locked=0
  - prev unchanged; no seq_err
- ACQ, legal sample: prev=q_in, good=0, go to TRACK.
- TRACK, legal sample:
  - q_in == nxt(prev): good+1. If good+1 == LOCK_N, go to LOCKED and set locked=1.
  - Otherwise: good=0 with no error pulse (still acquiring).
  - prev=q_in in both cases.
- LOCKED, legal sample:
  - q_in == nxt(prev): stay LOCKED.
  - Otherwise: seq_err=1, err_count+1 (saturating), locked=0, good=0, go to TRACK.
  - prev=q_in in both cases, so the new value becomes the reference.
- Wrap counting: wrap_count+1 on any legal sample in TRACK or LOCKED where prev == MODULUS-1 and q_in == 0, whether or not the state is locked.
- exp_q = nxt(prev) after each update. It is held when en=0.
- Saturation: err_count sticks at 2**CW-1. wrap_count wraps to 0.
- Reset mid-operation: reset wins over en. All state returns to reset values on the next edge regardless of inputs.
- Repeated value (counter stall): treated as a mismatch. In LOCKED it raises seq_err.
- LOCK_N=1: first correct increment after ACQ locks.

Decomposition:
- Package cntr12_pkg holds:
  - typedef enum {ACQ, TRACK, LOCKED} mon_state_t
  - localparam CNTR12_MOD = 12
  - function next_count(p) implementing the wrap rule, shared with the cntr12 RTL and benches
- One natural sub-module: sat_cntr (parameterised width; inc, clr; saturating) for err_count.
- wrap_count is a plain counter inline.

Test Plan:
- Reset, then en=1 with q_in 0,1,2,3 on consecutive cycles -> locked=1 the cycle after the sample q_in=3; exp_q=4; err_count=0.
- Locked at 11, then q_in=0 -> wrap_count=1, exp_q=1, no seq_err. Run 0..11 twice more -> wrap_count=3.
- Locked with prev=5, then q_in=7 -> seq_err pulse for exactly 1 cycle, locked=0, err_count=1. Then 8,9,10 -> locked=1 again.
- q_in=13 in LOCKED -> range_err=1, seq_err=0, locked=0, err_count+1. The next legal sample only re-enters TRACK.
- Feed 300 alternating 14/15 samples with CW=8 -> err_count saturates at 255 and stays there.
- Assert reset mid-lock with en=1 and a mismatching q_in -> no error pulse; next cycle all outputs equal reset values. Gaps with en=0 between samples do not break lock.
